bus_responder: RTL
==================

// Module: bus_responder
// PURPOSE
// Target end of the CPU memory/I-O bus. Decodes the CPU strobes and services them:
// - memory cycles: 2^ADDR_WIDTH x 8 RAM.
// - I/O cycles: two byte FIFOs (TX: CPU->external, RX: external->CPU) plus a status register.
// Sits beside the cpu instance on the shared bus; replaces a bare RAM model in the top level.
// PARAMETERS
// ADDR_WIDTH  8   RAM address width; RAM depth = 2**ADDR_WIDTH bytes
// FIFO_DEPTH  4   TX and RX FIFO depth; power of two, >= 2
// INIT_FILE   ""  hex image loaded into RAM at elaboration via $readmemh; empty = no load (RAM contents X)
// PORTS
// clk        in     1           system clock; same clock that feeds the cpu
// reset      in     1           synchronous, active-low reset
// addr_bus   in     ADDR_WIDTH  address from the CPU MAR
// c_ri       in     1           CPU write strobe: RAM write (mem_io=0) or I/O write (mem_io=1)
// c_ro       in     1           CPU read strobe: RAM read (mem_io=0) or I/O read (mem_io=1)
// mem_clk    in     1           CPU memory phase; sampled, only its rising edge is used
// mem_io     in     1           0 = memory cycle, 1 = I/O cycle
// bus        inout  8           shared data bus; driven only while c_ro=1, else high-Z
// out_data   out    8           TX FIFO head byte
// out_valid  out    1           TX FIFO non-empty
// out_ready  in     1           external consumer accepts out_data when out_valid & out_ready
// in_data    in     8           byte from the external producer
// in_valid   in     1           producer offers in_data
// in_ready   out    1           RX FIFO not full; byte taken when in_valid & in_ready
// BEHAVIOUR
// - Strobe: stb = mem_clk & ~mem_clk_q (mem_clk_q = mem_clk registered on clk). All CPU accesses act on stb cycles only.
// - Each stb cycle latches one action, in priority order:
//   1. c_ri & ~mem_io: ram[addr_bus] <= bus.
//   2. c_ro & ~mem_io: rd_q <= ram[addr_bus].
//   3. c_ri & mem_io & addr_bus[0]=0: push bus into the TX FIFO.
//   4. c_ro & mem_io & addr_bus[0]=0: rd_q <= RX head; RX pops.
//   5. c_ro & mem_io & addr_bus[0]=1: rd_q <= status; sticky bits clear in the same cycle.
//   6. c_ri & mem_io & addr_bus[0]=1: ignored.
//   c_ri and c_ro together: c_ri wins; no read occurs and bus is not driven.
// - Bus drive: bus = rd_q while c_ro=1 & c_ri=0, else 8'bz.
//   Data is valid from the clk edge after stb and is held until the next read stb.
//   The CPU samples on internal_clk, which follows mem_clk, so latency is 1 clk after stb.
// - Status byte: {4'b0, tx_ovf, rx_ovr, tx_full, rx_nonempty}.
//   tx_ovf: sticky; set on a TX push while TX is full.
//   rx_ovr: sticky; set on a CPU data read while RX is empty.
// - TX full on push: the byte is dropped and tx_ovf is set. A same-cycle external pop does NOT make room.
// - RX empty on CPU read: rd_q <= 8'h00, rx_ovr is set, the RX pointers are unchanged.
// - Simultaneous push and pop on one FIFO (not full/empty case): both take effect and count is unchanged.
// - in_ready = ~rx_full, registered-state based, so there is no combinational path from CPU strobes.
// - out_valid = ~tx_empty; out_data = TX head. out_data may change only after a handshake.
// - FIFO pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty; wrap is natural modulo.
// - Sticky bit set and a status-read clear in the same cycle: set wins.
// - Reset (reset=0 at a clk edge) applies regardless of in-flight strobes:
//   - FIFO pointers, sticky bits, rd_q and mem_clk_q clear to 0.
//   - RAM contents are untouched.
//   - Outputs after reset: out_valid=0, in_ready=1, out_data=X (don't care), bus high-Z unless c_ro=1, and then it drives 8'h00.
// - A stb coincident with reset is discarded.
// TESTING
// - RAM: write 8'hA5 to addr 8'h10 (c_ri, mem_io=0), then read addr 8'h10 -> bus=8'hA5 one clk after stb; bus high-Z once c_ro drops.
// - TX: 3 I/O data writes (11,22,33) with out_ready=0 -> out_valid=1, out_data=8'h11; raise out_ready -> 11,22,33 on consecutive clks, then out_valid=0.
// - TX overflow: FIFO_DEPTH+1 writes with out_ready=0 -> last byte dropped; status read=8'h0A (tx_ovf, tx_full); next status read=8'h02.
// - RX: push 8'h5C via in_valid/in_ready; status=8'h01; data read -> 8'h5C; a second data read -> 8'h00 with rx_ovr set (status=8'h04).
// - FIFO_DEPTH+1 in_valid pushes -> in_ready=0 after FIFO_DEPTH bytes; a CPU pop with in_valid held -> in_ready=1, then the next byte is accepted.
// - Assert reset mid-stream with TX holding 2 bytes and RX holding 1 -> out_valid=0, in_ready=1, status=8'h00, previously written RAM byte still readable.

Source files
------------

// File: rtl/bus_responder.sv
// Bus responder: target end of the CPU memory/I-O bus.
// Memory cycles hit a byte RAM; I/O cycles reach a TX FIFO (CPU -> external),
// an RX FIFO (external -> CPU) and a status register with sticky error bits.
// I/O map: addr_bus[0]=0 is the FIFO data port, addr_bus[0]=1 is status.
module bus_responder #(
  parameter int    ADDR_WIDTH = 8,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_bus,
  input  logic                  c_ri,
  input  logic                  c_ro,
  input  logic                  mem_clk,
  input  logic                  mem_io,
  inout  wire  [7:0]            bus,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  // One extra pointer bit tells full from empty; the low bits index storage.
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  // Pointers a whole FIFO apart differ only in the MSB.
  localparam ptr_t FULL_XOR = ptr_t'(FIFO_DEPTH);

  logic [7:0] ram    [2**ADDR_WIDTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  ptr_t       tx_wr, tx_rd, rx_wr, rx_rd;
  logic       mem_clk_q;
  logic       tx_ovf, rx_ovr;
  logic [7:0] rd_q;

  logic       stb, cpu_wr, cpu_rd;
  logic       ram_wr, ram_rd, tx_push_req, rx_pop_req, stat_rd;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] status;

  // Access decode: one action per mem_clk rising edge; a write beats a read.
  assign stb         = mem_clk & ~mem_clk_q;
  assign cpu_wr      = stb & c_ri;
  assign cpu_rd      = stb & c_ro & ~c_ri;
  assign ram_wr      = cpu_wr & ~mem_io;
  assign ram_rd      = cpu_rd & ~mem_io;
  assign tx_push_req = cpu_wr & mem_io & ~addr_bus[0];
  assign rx_pop_req  = cpu_rd & mem_io & ~addr_bus[0];
  assign stat_rd     = cpu_rd & mem_io & addr_bus[0];

  // FIFO flags come from registered pointers only, so in_ready has no path
  // from the CPU strobes.
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = ((tx_wr ^ tx_rd) == FULL_XOR);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = ((rx_wr ^ rx_rd) == FULL_XOR);

  // A push into a full TX is dropped even if the consumer pops the same cycle.
  assign tx_push = tx_push_req & ~tx_full;
  assign tx_pop  = ~tx_empty & out_ready;
  assign rx_push = in_valid & ~rx_full;
  assign rx_pop  = rx_pop_req & ~rx_empty;

  assign status = {4'b0000, tx_ovf, rx_ovr, tx_full, ~rx_empty};

  assign out_valid = ~tx_empty;
  assign out_data  = tx_mem[tx_rd[IDX_W-1:0]];
  assign in_ready  = ~rx_full;

  // Read data is presented only while the CPU reads and is not also writing.
  assign bus = (c_ro & ~c_ri) ? rd_q : 8'hzz;

  // RAM write port.
  // NOTE: storage arrays carry no reset; reset only suppresses the write so
  // contents survive it and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset && ram_wr) ram[addr_bus] <= bus;
  end

  // FIFO storage writes; gated by reset so a strobe during reset is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (tx_push) tx_mem[tx_wr[IDX_W-1:0]] <= bus;
      if (rx_push) rx_mem[rx_wr[IDX_W-1:0]] <= in_data;
    end
  end

  // Control state: strobe history, pointers, read latch and sticky bits.
  // NOTE: reset is synchronous and active-low, so it lives inside the clocked
  // branch; every state register here uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_clk_q <= 1'b0;
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      rd_q      <= 8'h00;
      tx_ovf    <= 1'b0;
      rx_ovr    <= 1'b0;
    end else begin
      mem_clk_q <= mem_clk;

      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;

      if (ram_rd)          rd_q <= ram[addr_bus];
      else if (rx_pop_req) rd_q <= rx_empty ? 8'h00 : rx_mem[rx_rd[IDX_W-1:0]];
      else if (stat_rd)    rd_q <= status;

      // A new error event outranks a status-read clear.
      tx_ovf <= (tx_push_req & tx_full)  | (tx_ovf & ~stat_rd);
      rx_ovr <= (rx_pop_req  & rx_empty) | (rx_ovr & ~stat_rd);
    end
  end

endmodule
